// File: rtl/pvp_hit_resolver_if.sv
// Bundle of frame-tick, player input and combat result signals for pvp_hit_resolver.
// master drives player inputs (game top / bench); slave is the resolver.
interface pvp_hit_resolver_if;
    logic       SCEN;
    logic       match_restart;
    logic [9:0] p1_pos_x;
    logic [9:0] p2_pos_x;
    logic [9:0] p1_pos_y;
    logic [9:0] p2_pos_y;
    logic       p1_facing_right;
    logic       p2_facing_right;
    logic       p1_atk_window;
    logic       p2_atk_window;
    logic       p1_hitstun_active;
    logic       p2_hitstun_active;
    logic       p1_hit_pulse;
    logic       p2_hit_pulse;
    logic [7:0] p1_hp;
    logic [7:0] p2_hp;
    logic       match_over;
    logic [1:0] winner;

    modport master (
        output SCEN, match_restart,
        output p1_pos_x, p2_pos_x, p1_pos_y, p2_pos_y,
        output p1_facing_right, p2_facing_right, p1_atk_window, p2_atk_window,
        input  p1_hitstun_active, p2_hitstun_active, p1_hit_pulse, p2_hit_pulse,
        input  p1_hp, p2_hp, match_over, winner
    );

    modport slave (
        input  SCEN, match_restart,
        input  p1_pos_x, p2_pos_x, p1_pos_y, p2_pos_y,
        input  p1_facing_right, p2_facing_right, p1_atk_window, p2_atk_window,
        output p1_hitstun_active, p2_hitstun_active, p1_hit_pulse, p2_hit_pulse,
        output p1_hp, p2_hp, match_over, winner
    );
endinterface

// File: rtl/pvp_hit_resolver.sv
// Frame-tick combat resolver: hitbox test, damage, per-player hitstun FSM, KO and winner.
// Optional macro PVP_HIT_IFRAMES_EN adds an invulnerability state after hitstun.
module pvp_hit_resolver #(
    parameter int HIT_RANGE_X    = 48,
    parameter int HIT_RANGE_Y    = 40,
    parameter int DAMAGE         = 10,
    parameter int MAX_HP         = 100,
    parameter int HITSTUN_FRAMES = 20,
    parameter int IFRAME_FRAMES  = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    pvp_hit_resolver_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STUN   = 2'd1,
        ST_IFRAME = 2'd2,
        ST_KO     = 2'd3
    } state_t;

    localparam logic [10:0] RANGE_X_C = 11'(HIT_RANGE_X);
    localparam logic [10:0] RANGE_Y_C = 11'(HIT_RANGE_Y);
    localparam logic [7:0]  DAMAGE_C  = 8'(DAMAGE);
    localparam logic [7:0]  MAX_HP_C  = 8'(MAX_HP);
    localparam logic [5:0]  HITSTUN_C = 6'(HITSTUN_FRAMES);
`ifdef PVP_HIT_IFRAMES_EN
    localparam logic [5:0]  IFRAME_C  = 6'(IFRAME_FRAMES);
`endif

    // Differences are taken at 11 bits so far-apart players never alias into range.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        d = {1'b0, b} - {1'b0, a};
        abs_diff = d[10] ? (11'd0 - d) : d;
    endfunction

    function automatic logic in_reach(input logic [9:0] ax, input logic [9:0] ay,
                                      input logic a_right,
                                      input logic [9:0] bx, input logic [9:0] by);
        logic front;
        front    = a_right ? (bx >= ax) : (bx <= ax);
        in_reach = (abs_diff(ax, bx) <= RANGE_X_C) && (abs_diff(ay, by) <= RANGE_Y_C) && front;
    endfunction

    function automatic logic [7:0] hp_after_hit(input logic [7:0] hp);
        hp_after_hit = (hp > DAMAGE_C) ? (hp - DAMAGE_C) : 8'd0;
    endfunction

    function automatic void fsm_next(input state_t st, input logic [5:0] cnt,
                                     input logic hit, input logic dead,
                                     output state_t ns, output logic [5:0] nc);
        ns = st;
        nc = cnt;
        case (st)
            ST_IDLE: begin
                if (hit) begin
                    ns = ST_STUN;
                    nc = HITSTUN_C - 6'd1;
                end else begin
                    ns = ST_IDLE;
                    nc = 6'd0;
                end
            end
            ST_STUN: begin
                if (cnt == 6'd0) begin
`ifdef PVP_HIT_IFRAMES_EN
                    ns = ST_IFRAME;
                    nc = IFRAME_C;
`else
                    ns = ST_IDLE;
                    nc = 6'd0;
`endif
                end else begin
                    nc = cnt - 6'd1;
                end
            end
            ST_IFRAME: begin
                if (cnt == 6'd0) begin
                    ns = ST_IDLE;
                    nc = 6'd0;
                end else begin
                    nc = cnt - 6'd1;
                end
            end
            ST_KO: begin
                ns = ST_KO;
                nc = 6'd0;
            end
            default: begin
                ns = ST_IDLE;
                nc = 6'd0;
            end
        endcase
        // Reaching zero HP wins over any counting transition.
        if (dead) begin
            ns = ST_KO;
            nc = 6'd0;
        end else begin
            ns = ns;
        end
    endfunction

    state_t     p1_state_r, p2_state_r, p1_state_nxt_s, p2_state_nxt_s;
    logic [5:0] p1_cnt_r, p2_cnt_r, p1_cnt_nxt_s, p2_cnt_nxt_s;
    logic [7:0] p1_hp_r, p2_hp_r, p1_hp_nxt_s, p2_hp_nxt_s;
    logic       p1_latch_r, p2_latch_r, p1_latch_nxt_s, p2_latch_nxt_s;
    logic       p1_hits_p2_s, p2_hits_p1_s, p1_dead_s, p2_dead_s;
    logic       p1_stun_r, p2_stun_r, p1_pulse_r, p2_pulse_r;
    logic       match_over_r, match_over_nxt_s;
    logic [1:0] winner_r, winner_nxt_s;

    // Hit detection, damage and next-state for both players, evaluated from current inputs.
    always_comb begin
        p1_hits_p2_s = bus.p1_atk_window && !p1_latch_r && (p2_state_r == ST_IDLE) && !match_over_r
                       && in_reach(bus.p1_pos_x, bus.p1_pos_y, bus.p1_facing_right,
                                   bus.p2_pos_x, bus.p2_pos_y);
        p2_hits_p1_s = bus.p2_atk_window && !p2_latch_r && (p1_state_r == ST_IDLE) && !match_over_r
                       && in_reach(bus.p2_pos_x, bus.p2_pos_y, bus.p2_facing_right,
                                   bus.p1_pos_x, bus.p1_pos_y);

        p1_hp_nxt_s = p2_hits_p1_s ? hp_after_hit(p1_hp_r) : p1_hp_r;
        p2_hp_nxt_s = p1_hits_p2_s ? hp_after_hit(p2_hp_r) : p2_hp_r;
        p1_dead_s   = (p1_hp_nxt_s == 8'd0);
        p2_dead_s   = (p2_hp_nxt_s == 8'd0);

        fsm_next(p1_state_r, p1_cnt_r, p2_hits_p1_s, p1_dead_s, p1_state_nxt_s, p1_cnt_nxt_s);
        fsm_next(p2_state_r, p2_cnt_r, p1_hits_p2_s, p2_dead_s, p2_state_nxt_s, p2_cnt_nxt_s);

        if (p1_hits_p2_s) begin
            p1_latch_nxt_s = 1'b1;
        end else if (!bus.p1_atk_window) begin
            p1_latch_nxt_s = 1'b0;
        end else begin
            p1_latch_nxt_s = p1_latch_r;
        end
        if (p2_hits_p1_s) begin
            p2_latch_nxt_s = 1'b1;
        end else if (!bus.p2_atk_window) begin
            p2_latch_nxt_s = 1'b0;
        end else begin
            p2_latch_nxt_s = p2_latch_r;
        end

        match_over_nxt_s = match_over_r | p1_dead_s | p2_dead_s;
        winner_nxt_s     = match_over_r ? winner_r : {p1_dead_s, p2_dead_s};
    end

    // State and result registers; restart behaves like reset and overrides the frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_state_r   <= ST_IDLE;
            p2_state_r   <= ST_IDLE;
            p1_cnt_r     <= 6'd0;
            p2_cnt_r     <= 6'd0;
            p1_hp_r      <= MAX_HP_C;
            p2_hp_r      <= MAX_HP_C;
            p1_latch_r   <= 1'b0;
            p2_latch_r   <= 1'b0;
            p1_stun_r    <= 1'b0;
            p2_stun_r    <= 1'b0;
            p1_pulse_r   <= 1'b0;
            p2_pulse_r   <= 1'b0;
            match_over_r <= 1'b0;
            winner_r     <= 2'b00;
        end else if (bus.match_restart) begin
            p1_state_r   <= ST_IDLE;
            p2_state_r   <= ST_IDLE;
            p1_cnt_r     <= 6'd0;
            p2_cnt_r     <= 6'd0;
            p1_hp_r      <= MAX_HP_C;
            p2_hp_r      <= MAX_HP_C;
            p1_latch_r   <= 1'b0;
            p2_latch_r   <= 1'b0;
            p1_stun_r    <= 1'b0;
            p2_stun_r    <= 1'b0;
            p1_pulse_r   <= 1'b0;
            p2_pulse_r   <= 1'b0;
            match_over_r <= 1'b0;
            winner_r     <= 2'b00;
        end else if (bus.SCEN) begin
            p1_state_r   <= p1_state_nxt_s;
            p2_state_r   <= p2_state_nxt_s;
            p1_cnt_r     <= p1_cnt_nxt_s;
            p2_cnt_r     <= p2_cnt_nxt_s;
            p1_hp_r      <= p1_hp_nxt_s;
            p2_hp_r      <= p2_hp_nxt_s;
            p1_latch_r   <= p1_latch_nxt_s;
            p2_latch_r   <= p2_latch_nxt_s;
            p1_stun_r    <= (p1_state_nxt_s == ST_STUN) || (p1_state_nxt_s == ST_KO);
            p2_stun_r    <= (p2_state_nxt_s == ST_STUN) || (p2_state_nxt_s == ST_KO);
            p1_pulse_r   <= p2_hits_p1_s;
            p2_pulse_r   <= p1_hits_p2_s;
            match_over_r <= match_over_nxt_s;
            winner_r     <= winner_nxt_s;
        end else begin
            p1_pulse_r   <= 1'b0;
            p2_pulse_r   <= 1'b0;
        end
    end

    assign bus.p1_hitstun_active = p1_stun_r;
    assign bus.p2_hitstun_active = p2_stun_r;
    assign bus.p1_hit_pulse      = p1_pulse_r;
    assign bus.p2_hit_pulse      = p2_pulse_r;
    assign bus.p1_hp             = p1_hp_r;
    assign bus.p2_hp             = p2_hp_r;
    assign bus.match_over        = match_over_r;
    assign bus.winner            = winner_r;

endmodule

// File: tb/tb_pvp_hit_resolver.sv
// Self-checking bench for pvp_hit_resolver: vector table plus multi-tick sequences,
// with expected outputs queued at each frame tick and popped when the result appears.
module tb_pvp_hit_resolver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef PVP_HIT_IFRAMES_EN
    localparam int GAP = 51;
`else
    localparam int GAP = 20;
`endif

    pvp_hit_resolver_if bus();
    pvp_hit_resolver_if bus_sat();

    pvp_hit_resolver u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
    // Second copy with MAX_HP=15 so a hit lands on hp=5 and must saturate at 0.
    pvp_hit_resolver #(.MAX_HP(15)) u_sat (.clk(clk), .reset(reset), .bus(bus_sat.slave));

    assign bus_sat.SCEN            = bus.SCEN;
    assign bus_sat.match_restart   = bus.match_restart;
    assign bus_sat.p1_pos_x        = bus.p1_pos_x;
    assign bus_sat.p2_pos_x        = bus.p2_pos_x;
    assign bus_sat.p1_pos_y        = bus.p1_pos_y;
    assign bus_sat.p2_pos_y        = bus.p2_pos_y;
    assign bus_sat.p1_facing_right = bus.p1_facing_right;
    assign bus_sat.p2_facing_right = bus.p2_facing_right;
    assign bus_sat.p1_atk_window   = bus.p1_atk_window;
    assign bus_sat.p2_atk_window   = bus.p2_atk_window;

    typedef struct {
        logic       p1_pulse;
        logic       p2_pulse;
        logic       p1_stun;
        logic       p2_stun;
        logic [7:0] p1_hp;
        logic [7:0] p2_hp;
        logic       over;
        logic [1:0] winner;
    } exp_t;

    typedef struct {
        logic       restart;
        logic [9:0] p1x, p1y, p2x, p2y;
        logic       p1f, p2f, p1w, p2w;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    vec_t tv[17];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(input logic p1p, input logic p2p, input logic s1, input logic s2,
                                input int h1, input int h2, input logic ov, input int w);
        exp_t e;
        e.p1_pulse = p1p;
        e.p2_pulse = p2p;
        e.p1_stun  = s1;
        e.p2_stun  = s2;
        e.p1_hp    = 8'(h1);
        e.p2_hp    = 8'(h2);
        e.over     = ov;
        e.winner   = 2'(w);
        return e;
    endfunction

    function automatic vec_t mkv(input logic rs, input int ax, input int ay, input int bx, input int by,
                                 input logic af, input logic bf, input logic aw, input logic bw,
                                 input exp_t e);
        vec_t v;
        v.restart = rs;
        v.p1x = 10'(ax); v.p1y = 10'(ay); v.p2x = 10'(bx); v.p2y = 10'(by);
        v.p1f = af; v.p2f = bf; v.p1w = aw; v.p2w = bw;
        v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic drive(input int ax, input int ay, input int bx, input int by,
                         input logic af, input logic bf, input logic aw, input logic bw);
        bus.p1_pos_x = 10'(ax); bus.p1_pos_y = 10'(ay);
        bus.p2_pos_x = 10'(bx); bus.p2_pos_y = 10'(by);
        bus.p1_facing_right = af; bus.p2_facing_right = bf;
        bus.p1_atk_window = aw; bus.p2_atk_window = bw;
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", nm);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "/p1_pulse"}, bus.p1_hit_pulse, e.p1_pulse);
            chk({nm, "/p2_pulse"}, bus.p2_hit_pulse, e.p2_pulse);
            chk({nm, "/p1_stun"},  bus.p1_hitstun_active, e.p1_stun);
            chk({nm, "/p2_stun"},  bus.p2_hitstun_active, e.p2_stun);
            chk({nm, "/p1_hp"},    bus.p1_hp, e.p1_hp);
            chk({nm, "/p2_hp"},    bus.p2_hp, e.p2_hp);
            chk({nm, "/over"},     bus.match_over, e.over);
            chk({nm, "/winner"},   bus.winner, e.winner);
        end
    endtask

    // One frame tick: queue the expectation, pulse SCEN, compare, then confirm pulses dropped.
    task automatic do_tick(input exp_t e, input string nm);
        @(negedge clk);
        bus.SCEN = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.SCEN = 1'b0;
        check_out(nm);
        @(posedge clk);
        #1;
        chk({nm, "/p1_pulse_end"}, bus.p1_hit_pulse, 0);
        chk({nm, "/p2_pulse_end"}, bus.p2_hit_pulse, 0);
    endtask

    task automatic do_restart();
        @(negedge clk);
        bus.match_restart = 1'b1;
        @(posedge clk);
        #1;
        bus.match_restart = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "/p1_hp"},    bus.p1_hp, 100);
        chk({nm, "/p2_hp"},    bus.p2_hp, 100);
        chk({nm, "/p1_stun"},  bus.p1_hitstun_active, 0);
        chk({nm, "/p2_stun"},  bus.p2_hitstun_active, 0);
        chk({nm, "/p1_pulse"}, bus.p1_hit_pulse, 0);
        chk({nm, "/p2_pulse"}, bus.p2_hit_pulse, 0);
        chk({nm, "/over"},     bus.match_over, 0);
        chk({nm, "/winner"},   bus.winner, 0);
    endtask

`ifdef PVP_HIT_IFRAMES_EN
    task automatic tick_only();
        @(negedge clk);
        bus.SCEN = 1'b1;
        @(posedge clk);
        #1;
        bus.SCEN = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t nh, h1, h2, st2, tr, e;
        int   hit_at;

        nh  = mk(1'b0, 1'b0, 1'b0, 1'b0, 100, 100, 1'b0, 0);
        h1  = mk(1'b1, 1'b0, 1'b1, 1'b0,  90, 100, 1'b0, 0);
        h2  = mk(1'b0, 1'b1, 1'b0, 1'b1, 100,  90, 1'b0, 0);
        st2 = mk(1'b0, 1'b0, 1'b0, 1'b1, 100,  90, 1'b0, 0);
        tr  = mk(1'b1, 1'b1, 1'b1, 1'b1,  90,  90, 1'b0, 0);

        tv[0]  = mkv(1'b1, 100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0, h2);   // basic hit
        tv[1]  = mkv(1'b0, 100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0, st2);  // same window, no rehit
        tv[2]  = mkv(1'b1, 100, 200, 140, 200, 1'b0, 1'b0, 1'b1, 1'b0, nh);   // facing away
        tv[3]  = mkv(1'b1, 100, 200, 149, 200, 1'b1, 1'b0, 1'b1, 1'b0, nh);   // dx=49
        tv[4]  = mkv(1'b1, 100, 200, 148, 200, 1'b1, 1'b0, 1'b1, 1'b0, h2);   // dx=48
        tv[5]  = mkv(1'b1, 100, 200,  52, 200, 1'b0, 1'b1, 1'b1, 1'b0, h2);   // dx=-48 facing left
        tv[6]  = mkv(1'b1, 100, 200, 140, 240, 1'b1, 1'b0, 1'b1, 1'b0, h2);   // dy=40
        tv[7]  = mkv(1'b1, 100, 200, 140, 241, 1'b1, 1'b0, 1'b1, 1'b0, nh);   // dy=41
        tv[8]  = mkv(1'b1, 100, 241, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0, nh);   // dy=-41
        tv[9]  = mkv(1'b1, 100, 200, 100, 200, 1'b1, 1'b0, 1'b1, 1'b0, h2);   // dx=0
        tv[10] = mkv(1'b1, 100, 200, 130, 200, 1'b1, 1'b0, 1'b1, 1'b1, tr);   // trade
        tv[11] = mkv(1'b1, 1000, 200, 10, 200, 1'b0, 1'b1, 1'b1, 1'b0, nh);   // far apart, no wrap
        tv[12] = mkv(1'b1, 100, 200, 149, 200, 1'b1, 1'b0, 1'b1, 1'b0, nh);   // miss
        tv[13] = mkv(1'b0, 100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0, h2);   // same window later hits
        tv[14] = mkv(1'b1, 100, 200, 140, 200, 1'b1, 1'b0, 1'b0, 1'b1, h1);   // P2 hits P1
        tv[15] = mkv(1'b1, 100, 200, 140, 200, 1'b1, 1'b1, 1'b0, 1'b1, nh);   // P2 facing away
        tv[16] = mkv(1'b1, 100, 200, 140, 200, 1'b1, 1'b0, 1'b0, 1'b0, nh);   // no window

        reset = 1'b1;
        bus.SCEN = 1'b0;
        bus.match_restart = 1'b0;
        drive(100, 200, 140, 200, 1'b1, 1'b0, 1'b0, 1'b0);
        #23;
        reset = 1'b0;
        #1;
        check_idle("reset");

        for (int i = 0; i < 17; i++) begin
            if (tv[i].restart) begin
                do_restart();
            end
            drive(tv[i].p1x, tv[i].p1y, tv[i].p2x, tv[i].p2y, tv[i].p1f, tv[i].p2f, tv[i].p1w, tv[i].p2w);
            do_tick(tv[i].e, $sformatf("vec%0d", i));
        end

        // Window held 7 ticks: single hit, 20 ticks of hitstun.
        do_restart();
        for (int k = 0; k < 25; k++) begin
            drive(100, 200, 140, 200, 1'b1, 1'b0, (k < 7), 1'b0);
            do_tick(mk(1'b0, (k == 0), 1'b0, (k < 20), 100, 90, 1'b0, 0), $sformatf("stun_k%0d", k));
            if (k == 0) begin
                chk("sat_first_hit_hp", bus_sat.p2_hp, 5);
            end
        end

        // Async reset while P2 is stunned.
        do_restart();
        drive(100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0);
        do_tick(h2, "pre_async");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        chk("async_reset/sat_hp", bus_sat.p2_hp, 15);
        @(negedge clk);
        reset = 1'b0;

        // Ten hits on P2: KO, winner P1; saturating copy KOs on its second hit.
        for (int h = 1; h <= 10; h++) begin
            drive(100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0);
            do_tick(mk(1'b0, 1'b1, 1'b0, 1'b1, 100, 100 - 10 * h, (h == 10), (h == 10) ? 1 : 0),
                    $sformatf("ko_hit%0d", h));
            if (h == 2) begin
                chk("sat_ko_hp", bus_sat.p2_hp, 0);
                chk("sat_ko_over", bus_sat.match_over, 1);
                chk("sat_ko_winner", bus_sat.winner, 1);
            end
            if (h < 10) begin
                for (int j = 1; j <= GAP; j++) begin
                    drive(100, 200, 140, 200, 1'b1, 1'b0, 1'b0, 1'b0);
                    do_tick(mk(1'b0, 1'b0, 1'b0, (j < 20), 100, 100 - 10 * h, 1'b0, 0),
                            $sformatf("ko_gap%0d_%0d", h, j));
                end
            end
        end
        for (int j = 0; j < 25; j++) begin
            drive(100, 200, 140, 200, 1'b1, 1'b0, j[0], 1'b0);
            do_tick(mk(1'b0, 1'b0, 1'b0, 1'b1, 100, 0, 1'b1, 1), $sformatf("after_ko%0d", j));
        end

        // Restart in the same cycle as a hitting frame tick.
        drive(100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.SCEN = 1'b1;
        bus.match_restart = 1'b1;
        @(posedge clk);
        #1;
        bus.SCEN = 1'b0;
        bus.match_restart = 1'b0;
        check_idle("restart_vs_scen");

        // Ten trades: double KO.
        for (int h = 1; h <= 10; h++) begin
            drive(100, 200, 130, 200, 1'b1, 1'b0, 1'b1, 1'b1);
            do_tick(mk(1'b1, 1'b1, 1'b1, 1'b1, 100 - 10 * h, 100 - 10 * h, (h == 10), (h == 10) ? 3 : 0),
                    $sformatf("dko_hit%0d", h));
            if (h < 10) begin
                for (int j = 1; j <= GAP; j++) begin
                    drive(100, 200, 130, 200, 1'b1, 1'b0, 1'b0, 1'b0);
                    e = mk(1'b0, 1'b0, (j < 20), (j < 20), 100 - 10 * h, 100 - 10 * h, 1'b0, 0);
                    do_tick(e, $sformatf("dko_gap%0d_%0d", h, j));
                end
            end
        end

`ifdef PVP_HIT_IFRAMES_EN
        // Re-attack inside invulnerability is ignored; held window lands once it ends.
        do_restart();
        drive(100, 200, 140, 200, 1'b1, 1'b0, 1'b1, 1'b0);
        tick_only();
        chk("iframe_first_hit", bus.p2_hit_pulse, 1);
        hit_at = -1;
        for (int t = 1; t <= 60; t++) begin
            drive(100, 200, 140, 200, 1'b1, 1'b0, (t == 25) || (t >= 51), 1'b0);
            tick_only();
            if (bus.p2_hit_pulse && hit_at < 0) begin
                hit_at = t;
            end
        end
        chk("iframe_hit_not_before_51", (hit_at >= 51), 1);
        chk("iframe_hit_by_52", (hit_at >= 0) && (hit_at <= 52), 1);
        chk("iframe_hp", bus.p2_hp, 80);
`else
        hit_at = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
